dmem_responder: RTL

//  Responder end of the core's data-memory load/store interface: accepts one request at a

---
 rtl/dmem_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port 64-bit data memory responder: one load/store at a time over valid/ready,
// fixed access latency, RV64 sizing with sign/zero extension and error detection.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request latched, latency counter running down
// RESP  | access done, response held until rsp_ready
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lat_write;
    logic [31:0]   lat_addr;
    logic [63:0]   lat_wdata;
    logic [2:0]    lat_funct3;

    logic [63:0]   mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [2:0]    lane;
    logic [5:0]    shamt;
    logic          out_of_range;
    logic          illegal;
    logic          misaligned;
    logic          acc_err;
    logic          access_now;
    logic          mem_we;
    logic [63:0]   rd_word;
    logic [63:0]   rd_shift;
    logic [63:0]   load_data;
    logic [7:0]    lane_mask;
    logic [7:0]    byte_en;
    logic [63:0]   wr_shift;
    logic [63:0]   wr_word;

    assign req_ready = rst && (state == IDLE);

    always_comb begin
        word_idx     = lat_addr[3 +: AW];
        lane         = lat_addr[2:0];
        shamt        = {lane, 3'b000};
        out_of_range = ({3'b000, lat_addr[31:3]} >= 32'(DEPTH));
        illegal      = lat_write ? lat_funct3[2] : (lat_funct3 == 3'b111);

        case (lat_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lat_addr[0];
            2'b10:   misaligned = |lat_addr[1:0];
            default: misaligned = |lat_addr[2:0];
        endcase
        acc_err = out_of_range || illegal || misaligned;

        rd_word  = mem[word_idx];
        rd_shift = rd_word >> shamt;

        case (lat_funct3)
            3'b000:  load_data = {{56{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  load_data = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_data = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b011:  load_data = rd_shift;
            3'b100:  load_data = {56'd0, rd_shift[7:0]};
            3'b101:  load_data = {48'd0, rd_shift[15:0]};
            3'b110:  load_data = {32'd0, rd_shift[31:0]};
            default: load_data = 64'd0;
        endcase

        case (lat_funct3[1:0])
            2'b00:   lane_mask = 8'h01;
            2'b01:   lane_mask = 8'h03;
            2'b10:   lane_mask = 8'h0f;
            default: lane_mask = 8'hff;
        endcase
        byte_en  = lane_mask << lane;
        wr_shift = lat_wdata << shamt;
        wr_word  = rd_word;
        for (int b = 0; b < 8; b++) begin
            if (byte_en[b]) wr_word[8*b +: 8] = wr_shift[8*b +: 8];
        end

        // The access happens exactly once, on the edge that leaves WAIT for RESP.
        access_now = (state == WAIT) && (cnt == '0);
        mem_we     = rst && access_now && lat_write && !acc_err;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 64'd0;
            rsp_err    <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 64'd0;
            lat_funct3 <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        lat_funct3 <= req_funct3;
                        cnt        <= CW'(LATENCY - 1);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || lat_write) ? 64'd0 : load_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
